// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: one-deep pipeline register between decode and the ALU.
// Captures an instruction on the valid/ready handshake, resolves operand
// sources, encodes the ALU opcode and holds everything stable until EX takes it.
// Build option: define FWD_EN to forward from EX/MEM and MEM/WB.
// Without it, the stage stalls decode on any RAW hazard against the
// in-flight writers.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic              use_imm,
  input  logic              is_rtype,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write_out,
  output logic              illegal_op
);

  logic            hazard_stall;
  logic            load;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_rs2;
  logic [3:0]      op_enc;
  logic            op_illegal;

`ifdef FWD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 always reads zero.
  function automatic logic [XLEN-1:0] fwd_value(input logic [REG_AW-1:0] rs,
                                                input logic [XLEN-1:0]   rf_data);
    if (rs == '0)                         return '0;
    else if (exm_wr_en && exm_rd == rs)   return exm_data;
    else if (mwb_wr_en && mwb_rd == rs)   return mwb_data;
    else                                  return rf_data;
  endfunction

  assign src_a        = fwd_value(rs1_addr, rs1_data);
  assign src_rs2      = fwd_value(rs2_addr, rs2_data);
  assign hazard_stall = 1'b0;
`else
  // A source is busy while any older instruction still owes a write to it.
  function automatic logic src_busy(input logic [REG_AW-1:0] rs);
    return (rs != '0) &&
           ((exm_wr_en && exm_rd == rs) ||
            (mwb_wr_en && mwb_rd == rs) ||
            (out_valid && reg_write_out && rd_out == rs));
  endfunction

  logic unused_fwd_data;
  assign unused_fwd_data = ^{exm_data, mwb_data};

  assign src_a   = rs1_data;
  assign src_rs2 = rs2_data;
  // rs2 is always checked: store_data carries rs2 even when B takes the
  // immediate, and this stage cannot tell a store from other I-type ops.
  assign hazard_stall = in_valid && (src_busy(rs1_addr) || src_busy(rs2_addr));
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard_stall;
  assign load     = in_valid && in_ready;

  // funct3 to ALU opcode; unsupported encodings fall back to ADD and are flagged.
  always_comb begin
    op_enc     = 4'b0000;
    op_illegal = 1'b0;
    case (funct3)
      3'b000:  op_enc = (is_rtype && funct7b5) ? 4'b1000 : 4'b0000;
      3'b111:  op_enc = 4'b0111;
      3'b110:  op_enc = 4'b0110;
      3'b100:  op_enc = 4'b0100;
      3'b010:  op_enc = 4'b0010;
      3'b001:  op_enc = 4'b0001;
      default: op_illegal = 1'b1;
    endcase
  end

  // Pipeline register: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= 4'b0000;
      store_data    <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      illegal_op    <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      alu_a         <= src_a;
      alu_b         <= use_imm ? imm : src_rs2;
      alu_op        <= op_enc;
      store_data    <= src_rs2;
      rd_out        <= rd_addr;
      reg_write_out <= reg_write;
      illegal_op    <= op_illegal;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, checked against a behavioural reference model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exm_rd, mwb_rd, rd_out;
  logic [31:0] rs1_data, rs2_data, imm, exm_data, mwb_data;
  logic        use_imm, is_rtype, funct7b5, reg_write, exm_wr_en, mwb_wr_en, flush;
  logic [2:0]  funct3;
  logic        out_valid, out_ready, reg_write_out, illegal_op;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_op;

  id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .use_imm(use_imm), .is_rtype(is_rtype), .funct3(funct3), .funct7b5(funct7b5),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  // funct3 -> ALU opcode, -1 marks encodings the ALU does not implement.
  int   op_tbl[8] = '{0, 1, 2, -1, 4, -1, 6, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_src(input logic [4:0] rs, input logic [31:0] rf);
`ifdef FWD_EN
    if (rs == 0) return 32'h0;
    if (exm_wr_en && exm_rd == rs) return exm_data;
    if (mwb_wr_en && mwb_rd == rs) return mwb_data;
    return rf;
`else
    return rf;
`endif
  endfunction

  function automatic bit ref_busy(input logic [4:0] rs);
    bit held_wr;
    held_wr = (q.size() != 0) && q[0].rw && (q[0].rd == rs);
    return (rs != 0) && ((exm_wr_en && exm_rd == rs) || (mwb_wr_en && mwb_rd == rs) || held_wr);
  endfunction

  function automatic bit ref_stall();
`ifdef FWD_EN
    return 1'b0;
`else
    return in_valid && (ref_busy(rs1_addr) || ref_busy(rs2_addr));
`endif
  endfunction

  // One clock of stimulus: inputs are already set at the falling edge.
  task automatic step();
    bit   exp_ready, accept;
    exp_t e;
    int   code;
    #1;
    exp_ready = ((q.size() == 0) || out_ready) && !ref_stall();
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    accept = in_valid && exp_ready && !flush;
    e.a  = ref_src(rs1_addr, rs1_data);
    e.sd = ref_src(rs2_addr, rs2_data);
    e.b  = use_imm ? imm : e.sd;
    e.rd = rd_addr;
    e.rw = reg_write;
    code = op_tbl[funct3];
    e.ill = (code < 0);
    if (code < 0)                               e.op = 4'd0;
    else if (funct3 == 3'd0 && is_rtype && funct7b5) e.op = 4'd8;
    else                                        e.op = 4'(code);
    #2;
    if (accept) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0; imm = 0;
    use_imm = 0; is_rtype = 0; funct3 = 0; funct7b5 = 0; rd_addr = 0; reg_write = 0;
    exm_wr_en = 0; exm_rd = 0; exm_data = 0; mwb_wr_en = 0; mwb_rd = 0; mwb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  // Monitor: compares whatever the DUT presents against the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("reg_write_out", {31'b0, reg_write_out}, {31'b0, q[0].rw});
        chk("alu_a", alu_a, q[0].a);
        chk("alu_b", alu_b, q[0].b);
        chk("store_data", store_data, q[0].sd);
        chk("alu_op", {28'b0, alu_op}, {28'b0, q[0].op});
        chk("rd_out", {27'b0, rd_out}, {27'b0, q[0].rd});
        chk("illegal_op", {31'b0, illegal_op}, {31'b0, q[0].ill});
        if (flush || out_ready) void'(q.pop_front());
      end else begin
        chk("reg_write_out_idle", {31'b0, reg_write_out}, 32'h0);
      end
    end
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset while an instruction is held under backpressure.
    rs1_addr = 5; rs1_data = 32'h1234; imm = 7; use_imm = 1; funct3 = 3'b011;
    rd_addr = 3; reg_write = 1; in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    step();
    rst_n = 0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'h0);
    chk("rst_store_data", store_data, 32'h0);
    chk("rst_rd_out", {27'b0, rd_out}, 32'h0);
    chk("rst_reg_write_out", {31'b0, reg_write_out}, 32'h0);
    chk("rst_illegal_op", {31'b0, illegal_op}, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1;

    // ADD with immediate.
    clear_inputs();
    rs1_addr = 5; rs1_data = 3; imm = 7; use_imm = 1; funct3 = 3'b000; in_valid = 1;
    step();
    in_valid = 0;
    step();

    // SUB needs R-type; the same encoding as I-type is ADD.
    clear_inputs();
    rs1_addr = 4; rs2_addr = 1; rs1_data = 32'h50; rs2_data = 32'h11;
    is_rtype = 1; funct7b5 = 1; in_valid = 1;
    step();
    is_rtype = 0;
    step();
    in_valid = 0;
    step();

    // Both writers target rs1; then x0 against a writer claiming x0.
    clear_inputs();
    rs1_addr = 6; rs1_data = 32'h66; exm_wr_en = 1; exm_rd = 6; exm_data = 32'hAA;
    mwb_wr_en = 1; mwb_rd = 6; mwb_data = 32'hBB; in_valid = 1;
    step();
    rs1_addr = 0; rs1_data = 32'h55; exm_rd = 0; mwb_wr_en = 0;
    step();
    clear_inputs();
    step();

    // rs2 hazard against EX/MEM until the writer goes away.
    clear_inputs();
    rs2_addr = 9; rs2_data = 32'h99; exm_wr_en = 1; exm_rd = 9; exm_data = 32'h900;
    in_valid = 1;
    step();
    step();
    exm_wr_en = 0;
    step();
    in_valid = 0;
    step();

    // Backpressure two cycles, then flush the held instruction.
    clear_inputs();
    rs1_addr = 2; rs2_addr = 3; rs1_data = 32'h22; rs2_data = 32'h33; rd_addr = 12;
    reg_write = 1; funct3 = 3'b110; in_valid = 1; out_ready = 0;
    step();
    step();
    step();
    flush = 1;
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    step();

    // Randomized traffic with a small register window to provoke hazards.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = 5'($urandom_range(0, 7));
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      imm       = $urandom;
      use_imm   = 1'($urandom_range(0, 1));
      is_rtype  = 1'($urandom_range(0, 1));
      funct3    = 3'($urandom_range(0, 7));
      funct7b5  = 1'($urandom_range(0, 1));
      rd_addr   = 5'($urandom_range(0, 7));
      reg_write = 1'($urandom_range(0, 1));
      exm_wr_en = ($urandom_range(0, 2) == 0);
      exm_rd    = 5'($urandom_range(0, 7));
      exm_data  = $urandom;
      mwb_wr_en = ($urandom_range(0, 2) == 0);
      mwb_rd    = 5'($urandom_range(0, 7));
      mwb_data  = $urandom;
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    clear_inputs();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
